uart_tx_arb: RTL and testbench

Packet-locking round-robin arbiter that shares the single UART transmitter byte interface (tx_data / new_tx_data / tx_busy) among NREQ byte-stream requesters, e.g. the parser response path and the miner result reporter. Each requester presents bytes with a last-byte marker. Once granted, a requester owns the transmitter until its last byte has been sent, so packets never interleave on the serial line. The block sits between the requesters and uart_top inside uart2core.

---
 rtl/uart_tx_arb.sv | 183 ++++++++++++++++++
 tb/tb_uart_tx_arb.sv | 372 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arb.sv
// Packet-locking round-robin arbiter in front of the UART transmitter byte port.
// A granted requester keeps the transmitter until its last-marked byte has been sent.
module uart_tx_arb #(
    parameter int NREQ      = 2,
    parameter int BUSY_WAIT = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [8*NREQ-1:0]    req_data,
    input  logic [NREQ-1:0]      req_last,
    output logic [NREQ-1:0]      req_ready,
    output logic [NREQ-1:0]      grant,
    output logic [7:0]           tx_data,
    output logic                 new_tx_data,
    input  logic                 tx_busy,
    output logic                 tx_timeout,
    output logic                 arb_busy
);

    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int SW    = IDX_W + 1;
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_BUSY = 2'd1,
        WAIT_DONE = 2'd2,
        HOLD      = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               last_flag_q, last_flag_d;
    logic [NREQ-1:0]    grant_q, grant_d;
    logic [NREQ-1:0]    req_ready_q, req_ready_d;
    logic [7:0]         tx_data_q, tx_data_d;
    logic               new_tx_data_q, new_tx_data_d;
    logic               tx_timeout_q, tx_timeout_d;
    logic               arb_busy_q, arb_busy_d;

    logic               load_en;
    logic               release_en;
    logic [IDX_W-1:0]   load_idx;
    logic [IDX_W:0]     pick;

    // Returns {found, index} of the first valid requester at or after start, wrapping.
    function automatic logic [IDX_W:0] pick_first(input logic [NREQ-1:0]  valid,
                                                  input logic [IDX_W-1:0] start);
        logic [IDX_W:0]   res;
        logic [SW-1:0]    sum;
        logic [IDX_W-1:0] idx;
        res = '0;
        for (int k = 0; k < NREQ; k++) begin
            sum = {1'b0, start} + SW'(k);
            if (sum >= SW'(NREQ)) begin
                sum = sum - SW'(NREQ);
            end
            idx = sum[IDX_W-1:0];
            if (!res[IDX_W] && valid[idx]) begin
                res = {1'b1, idx};
            end
        end
        return res;
    endfunction

    function automatic logic [IDX_W-1:0] next_ptr(input logic [IDX_W-1:0] idx);
        if (idx == IDX_W'(NREQ - 1)) begin
            return '0;
        end
        return idx + 1'b1;
    endfunction

    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        rr_ptr_d      = rr_ptr_q;
        cnt_d         = cnt_q;
        last_flag_d   = last_flag_q;
        grant_d       = grant_q;
        tx_data_d     = tx_data_q;
        req_ready_d   = '0;
        new_tx_data_d = 1'b0;
        tx_timeout_d  = 1'b0;
        load_en       = 1'b0;
        release_en    = 1'b0;
        load_idx      = owner_q;
        pick          = pick_first(req_valid, rr_ptr_q);

        case (state_q)
            IDLE: begin
                if (!tx_busy && pick[IDX_W]) begin
                    load_en  = 1'b1;
                    load_idx = pick[IDX_W-1:0];
                end
            end
            WAIT_BUSY: begin
                if (tx_busy) begin
                    state_d = WAIT_DONE;
                end else if (cnt_q == CNT_W'(BUSY_WAIT)) begin
                    // The transmitter never acknowledged; move on as if the byte went out.
                    tx_timeout_d = 1'b1;
                    release_en   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            WAIT_DONE: begin
                if (!tx_busy) begin
                    release_en = 1'b1;
                end
            end
            HOLD: begin
                if (req_valid[owner_q]) begin
                    load_en = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (release_en) begin
            if (last_flag_q) begin
                grant_d  = '0;
                rr_ptr_d = next_ptr(owner_q);
                state_d  = IDLE;
            end else begin
                state_d  = HOLD;
            end
        end

        if (load_en) begin
            owner_d              = load_idx;
            grant_d              = '0;
            grant_d[load_idx]    = 1'b1;
            req_ready_d[load_idx] = 1'b1;
            tx_data_d            = req_data[8*load_idx +: 8];
            last_flag_d          = req_last[load_idx];
            new_tx_data_d        = 1'b1;
            cnt_d                = '0;
            state_d              = WAIT_BUSY;
        end

        arb_busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            owner_q       <= '0;
            rr_ptr_q      <= '0;
            cnt_q         <= '0;
            last_flag_q   <= 1'b0;
            grant_q       <= '0;
            req_ready_q   <= '0;
            tx_data_q     <= 8'h00;
            new_tx_data_q <= 1'b0;
            tx_timeout_q  <= 1'b0;
            arb_busy_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            owner_q       <= owner_d;
            rr_ptr_q      <= rr_ptr_d;
            cnt_q         <= cnt_d;
            last_flag_q   <= last_flag_d;
            grant_q       <= grant_d;
            req_ready_q   <= req_ready_d;
            tx_data_q     <= tx_data_d;
            new_tx_data_q <= new_tx_data_d;
            tx_timeout_q  <= tx_timeout_d;
            arb_busy_q    <= arb_busy_d;
        end
    end

    assign grant       = grant_q;
    assign req_ready   = req_ready_q;
    assign tx_data     = tx_data_q;
    assign new_tx_data = new_tx_data_q;
    assign tx_timeout  = tx_timeout_q;
    assign arb_busy    = arb_busy_q;

endmodule

// File: tb/tb_uart_tx_arb.sv
// Bench for uart_tx_arb: two byte-stream requesters, a uart_top busy responder,
// a timeline model of the arbitration rules and directed packet scenarios.
module tb_uart_tx_arb;

    localparam int NREQ      = 2;
    localparam int BUSY_WAIT = 4;
    localparam int BUSY_LEN  = 10;

    logic                clk;
    logic                rst;
    logic [NREQ-1:0]     req_valid;
    logic [8*NREQ-1:0]   req_data;
    logic [NREQ-1:0]     req_last;
    logic [NREQ-1:0]     req_ready;
    logic [NREQ-1:0]     grant;
    logic [7:0]          tx_data;
    logic                new_tx_data;
    logic                tx_busy;
    logic                tx_timeout;
    logic                arb_busy;

    uart_tx_arb #(.NREQ(NREQ), .BUSY_WAIT(BUSY_WAIT)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_last    (req_last),
        .req_ready   (req_ready),
        .grant       (grant),
        .tx_data     (tx_data),
        .new_tx_data (new_tx_data),
        .tx_busy     (tx_busy),
        .tx_timeout  (tx_timeout),
        .arb_busy    (arb_busy)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // requester queues ({last, byte}): dq* feed the pins, mq* belong to the model
    logic [8:0] dq0[$], dq1[$], mq0[$], mq1[$];
    logic [1:0] en;
    bit         auto_busy;
    int         busy_cnt;

    // logs of what the DUT emitted, for literal checks
    logic [7:0] log_b[$];
    logic [1:0] log_g[$];
    int         strobe_cyc[$];
    int         to_cyc[$];

    // model state
    int         cyc;
    int         m_owner, m_sent, m_busy, m_rr;
    bit         m_last;
    logic [7:0] m_tx;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, n_cmp=%0d", n_cmp);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic push(input int i, input bit last, input logic [7:0] b);
        if (i == 0) begin
            dq0.push_back({last, b});
            mq0.push_back({last, b});
        end else begin
            dq1.push_back({last, b});
            mq1.push_back({last, b});
        end
    endtask

    function automatic logic [31:0] lb(input int i);
        if (i < log_b.size()) return 32'(log_b[i]);
        return 32'hDEAD;
    endfunction

    function automatic logic [31:0] lg(input int i);
        if (i < log_g.size()) return 32'(log_g[i]);
        return 32'hDEAD;
    endfunction

    function automatic logic [31:0] lsc(input int i);
        if (i < strobe_cyc.size()) return 32'(strobe_cyc[i]);
        return 32'hDEAD;
    endfunction

    function automatic logic [31:0] ltc(input int i);
        if (i < to_cyc.size()) return 32'(to_cyc[i]);
        return 32'hDEAD;
    endfunction

    task automatic clear_logs();
        log_b.delete();
        log_g.delete();
        strobe_cyc.delete();
        to_cyc.delete();
    endtask

    task automatic wait_log(input int n, input int budget, input string name);
        int w = 0;
        while (log_b.size() < n && w < budget) begin
            @(negedge clk);
            w++;
        end
        check(name, 32'(log_b.size() >= n), 32'd1);
    endtask

    task automatic wait_idle(input int budget, input string name);
        int w = 0;
        while (!(dq0.size() == 0 && dq1.size() == 0 && m_owner < 0 && m_sent < 0) && w < budget) begin
            @(negedge clk);
            w++;
        end
        check(name, 32'(m_owner < 0 && m_sent < 0 && dq0.size() == 0 && dq1.size() == 0), 32'd1);
        repeat (2) @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_grant"}, 32'(grant), 32'd0);
        check({tag, "_req_ready"}, 32'(req_ready), 32'd0);
        check({tag, "_tx_data"}, 32'(tx_data), 32'd0);
        check({tag, "_new_tx_data"}, 32'(new_tx_data), 32'd0);
        check({tag, "_tx_timeout"}, 32'(tx_timeout), 32'd0);
        check({tag, "_arb_busy"}, 32'(arb_busy), 32'd0);
    endtask

    // requester drivers: advance on req_ready, present the queue head
    initial begin
        logic [8:0] h0, h1;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        forever begin
            @(negedge clk);
            if (req_ready[0] && dq0.size() > 0) void'(dq0.pop_front());
            if (req_ready[1] && dq1.size() > 0) void'(dq1.pop_front());
            h0 = (dq0.size() > 0) ? dq0[0] : 9'h000;
            h1 = (dq1.size() > 0) ? dq1[0] : 9'h000;
            req_valid[0]    = en[0] && (dq0.size() > 0);
            req_valid[1]    = en[1] && (dq1.size() > 0);
            req_data[7:0]   = h0[7:0];
            req_data[15:8]  = h1[7:0];
            req_last[0]     = h0[8];
            req_last[1]     = h1[8];
        end
    end

    // uart_top stand-in: busy rises the cycle after the strobe and lasts BUSY_LEN cycles
    initial begin
        tx_busy  = 1'b0;
        busy_cnt = 0;
        forever begin
            @(negedge clk);
            if (!rst || !auto_busy) begin
                busy_cnt = 0;
                tx_busy  = 1'b0;
            end else begin
                if (busy_cnt > 0) begin
                    tx_busy = 1'b1;
                    busy_cnt--;
                end else begin
                    tx_busy = 1'b0;
                end
                if (new_tx_data) busy_cnt = BUSY_LEN;
            end
        end
    end

    // Timeline model: each byte is in flight from its strobe until busy has been seen and
    // has fallen (or BUSY_WAIT cycles elapse with no busy); a load may be decided only
    // while nothing is in flight. Inputs read here are those the DUT just sampled.
    initial begin
        bit              e_strobe, e_to, rel;
        int              e_sel, j;
        logic [8:0]      h;
        logic [NREQ-1:0] e_grant, e_ready;
        logic            e_busy;
        cyc = 0;
        m_owner = -1; m_sent = -1; m_busy = -1; m_rr = 0; m_last = 0; m_tx = 8'h00;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (!rst) begin
                m_owner = -1; m_sent = -1; m_busy = -1; m_rr = 0; m_last = 0; m_tx = 8'h00;
            end else begin
                e_strobe = 0; e_to = 0; rel = 0; e_sel = 0;
                if (m_sent >= 0) begin
                    if (m_busy < 0) begin
                        if (tx_busy) m_busy = cyc - 1;
                        else if ((cyc - 1) - m_sent == BUSY_WAIT) begin
                            e_to = 1;
                            rel  = 1;
                        end
                    end else if (!tx_busy) begin
                        rel = 1;
                    end
                    if (rel) begin
                        m_sent = -1;
                        if (m_last) begin
                            m_rr    = (m_owner + 1) % NREQ;
                            m_owner = -1;
                        end
                    end
                end else begin
                    if (m_owner >= 0) begin
                        if (req_valid[m_owner]) begin
                            e_strobe = 1;
                            e_sel    = m_owner;
                        end
                    end else if (!tx_busy) begin
                        for (int k = 0; k < NREQ; k++) begin
                            j = (m_rr + k) % NREQ;
                            if (!e_strobe && req_valid[j]) begin
                                e_strobe = 1;
                                e_sel    = j;
                            end
                        end
                    end
                    if (e_strobe) begin
                        h = 9'h1FF;
                        if (e_sel == 0 && mq0.size() > 0) h = mq0.pop_front();
                        if (e_sel == 1 && mq1.size() > 0) h = mq1.pop_front();
                        m_last  = h[8];
                        m_tx    = h[7:0];
                        m_owner = e_sel;
                        m_sent  = cyc;
                        m_busy  = -1;
                    end
                end
                e_grant = '0;
                if (m_owner >= 0) e_grant[m_owner] = 1'b1;
                e_ready = '0;
                if (e_strobe) e_ready[e_sel] = 1'b1;
                e_busy = (m_sent >= 0) || (m_owner >= 0);
                check("new_tx_data", 32'(new_tx_data), 32'(e_strobe));
                check("req_ready", 32'(req_ready), 32'(e_ready));
                check("grant", 32'(grant), 32'(e_grant));
                check("tx_data", 32'(tx_data), 32'(m_tx));
                check("tx_timeout", 32'(tx_timeout), 32'(e_to));
                check("arb_busy", 32'(arb_busy), 32'(e_busy));
                if (new_tx_data) begin
                    log_b.push_back(tx_data);
                    log_g.push_back(grant);
                    strobe_cyc.push_back(cyc);
                end
                if (tx_timeout) to_cyc.push_back(cyc);
            end
        end
    end

    initial begin
        rst       = 1'b0;
        en        = 2'b11;
        auto_busy = 1'b1;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b1;

        // single byte
        push(0, 1, 8'hA5);
        wait_log(1, 50, "t1_strobe_seen");
        wait_idle(100, "t1_done");
        check("t1_count", 32'(log_b.size()), 32'd1);
        check("t1_byte", lb(0), 32'hA5);
        check("t1_grant", lg(0), 32'h1);
        check("t1_grant_end", 32'(grant), 32'h0);
        clear_logs();

        // packet lock: req1 arrives after req0's first byte and must wait for 8'h03
        push(0, 0, 8'h01);
        push(0, 0, 8'h02);
        push(0, 1, 8'h03);
        wait_log(1, 50, "t2_strobe_seen");
        push(1, 1, 8'hFF);
        wait_idle(200, "t2_done");
        check("t2_byte0", lb(0), 32'h01);
        check("t2_byte1", lb(1), 32'h02);
        check("t2_byte2", lb(2), 32'h03);
        check("t2_byte3", lb(3), 32'hFF);
        check("t2_grant2", lg(2), 32'h1);
        check("t2_grant3", lg(3), 32'h2);
        clear_logs();

        // round robin from reset
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        push(0, 1, 8'h10);
        push(0, 1, 8'h10);
        push(1, 1, 8'h20);
        push(1, 1, 8'h20);
        wait_idle(200, "t3_done");
        check("t3_byte0", lb(0), 32'h10);
        check("t3_byte1", lb(1), 32'h20);
        check("t3_byte2", lb(2), 32'h10);
        check("t3_byte3", lb(3), 32'h20);
        clear_logs();

        // HOLD stall: owner goes quiet mid-packet, req1 is valid but ignored
        push(0, 0, 8'h55);
        push(1, 1, 8'h77);
        wait_log(1, 50, "t4_strobe_seen");
        en[0] = 1'b0;
        push(0, 1, 8'h66);
        repeat (20) @(negedge clk);
        check("t4_gap_count", 32'(log_b.size()), 32'd1);
        check("t4_gap_grant", 32'(grant), 32'h1);
        check("t4_gap_arb_busy", 32'(arb_busy), 32'd1);
        en[0] = 1'b1;
        wait_idle(200, "t4_done");
        check("t4_byte0", lb(0), 32'h55);
        check("t4_byte1", lb(1), 32'h66);
        check("t4_byte2", lb(2), 32'h77);
        check("t4_grant2", lg(2), 32'h2);
        clear_logs();

        // timeout: transmitter never goes busy
        auto_busy = 1'b0;
        push(0, 0, 8'hC1);
        push(0, 1, 8'hC2);
        wait_idle(100, "t5_done");
        check("t5_timeouts", 32'(to_cyc.size()), 32'd2);
        check("t5_to_delay", ltc(0) - lsc(0), 32'd5);
        check("t5_strobe_gap", lsc(1) - lsc(0), 32'd6);
        check("t5_byte0", lb(0), 32'hC1);
        check("t5_byte1", lb(1), 32'hC2);
        auto_busy = 1'b1;
        clear_logs();

        // reset in WAIT_DONE; pointer would otherwise favour req1
        push(1, 0, 8'hD1);
        push(1, 1, 8'hD2);
        wait_log(1, 50, "t6_strobe_seen");
        repeat (4) @(negedge clk);
        check("t6_busy_before", 32'(arb_busy), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        check_all_zero("t6_async");
        dq0.delete(); dq1.delete(); mq0.delete(); mq1.delete();
        clear_logs();
        push(0, 1, 8'hE0);
        push(1, 1, 8'hE1);
        @(negedge clk);
        rst = 1'b1;
        wait_idle(200, "t6_done");
        check("t6_byte0", lb(0), 32'hE0);
        check("t6_grant0", lg(0), 32'h1);
        check("t6_byte1", lb(1), 32'hE1);
        check("t6_grant1", lg(1), 32'h2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
